gb_pool_responder: RTL and testbench
====================================

Name: gb_pool_responder

Overview:
- Global-buffer-side responder for the POOL read interface. It is the other end of the POOLGB_addr / GBPOOL_data handshake.
- Holds a single-port psum bank (DEPTH words of NUM_CH signed psums), written by the PE array side.
- Serves POOL read requests with a 1-cycle synchronous-SRAM fetch and a registered response stage.
- Sits between the PE psum write path and inst_POOL inside TS3D.

Parameters:
- PSUM_WIDTH, 20, bits per signed psum lane.
- NUM_CH, 16, psum lanes per word; word width is NUM_CH*PSUM_WIDTH.
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH.

Ports:
- Clk  input  1  single clock, all logic rising-edge.
- Reset  input  1  synchronous, active-high reset.
- PEGB_val  input  1  psum write request.
- PEGB_addr  input  ADDR_WIDTH  write address.
- PEGB_data  input  NUM_CH*PSUM_WIDTH  write data; lane j at [PSUM_WIDTH*j +: PSUM_WIDTH].
- GBPE_rdy  output  1  write accept; low only while in reset.
- POOLGB_rdy  input  1  POOL requests a read and is ready to take data.
- POOLGB_addr  input  ADDR_WIDTH  read address; held stable by POOL while POOLGB_rdy is high.
- GBPOOL_val  output  1  response data valid.
- GBPOOL_data  output  NUM_CH*PSUM_WIDTH  response word, same lane packing.
- GBPOOL_cnt  output  16  number of completed read transfers since reset, wraps at 65535->0.

Behaviour:
- Reset values: GBPOOL_val=0, GBPOOL_data=0, GBPOOL_cnt=0, GBPE_rdy=0, FSM=IDLE.
- Reset does not clear memory contents.
- Reset asserted mid-transaction aborts it. No transfer is counted, and GBPOOL_val is low on the next cycle.
- The write and read paths share one memory port. A write fires when PEGB_val && GBPE_rdy and always wins the port that cycle.
- FSM states:
  - IDLE: if POOLGB_rdy, go to FETCH.
  - FETCH: issue a memory read of POOLGB_addr, capture the address into req_addr, go to RESP.
    - If a write occupies the port this cycle, no read is issued and the FSM stays in FETCH.
    - If POOLGB_rdy drops, go to IDLE.
  - RESP: register the read data into GBPOOL_data, assert GBPOOL_val, go to HOLD.
  - HOLD: GBPOOL_val=1.
    - Transfer completes in any HOLD cycle with POOLGB_rdy=1: GBPOOL_cnt += 1.
    - On that cycle, go to FETCH if POOLGB_rdy is still high next cycle, otherwise IDLE. In both cases GBPOOL_val drops the following cycle.
    - If POOLGB_rdy=0 in HOLD: abort, go to IDLE, drop GBPOOL_val, no count.
- Latency: POOLGB_rdy rising in IDLE gives GBPOOL_val=1 three cycles later (IDLE, FETCH, RESP).
- Sustained throughput is one word per 3 cycles when no writes collide.
- Address change while in RESP/HOLD (POOLGB_addr != req_addr): the current word is not transferred. GBPOOL_val drops and the FSM returns to FETCH to refetch.
- Read-after-write hazard: a write to req_addr while in RESP or HOLD forces a refetch through FETCH. POOL never receives stale data.
- GBPOOL_data holds its last value when GBPOOL_val=0.
- Writes to any address are legal in all states. Address wrap is implicit modulo DEPTH.

Optional Feature:
- Macro: GB_POOL_CLR_ON_READ_EN.
- Defined: on each completed transfer, the entry at req_addr is written to all-zero on the following cycle. This uses the port; a simultaneous PE write to any address is stalled for that cycle (GBPE_rdy=0). The zeroing happens before any later read can observe the entry.
- Undefined: reads are non-destructive and GBPE_rdy is high whenever not in reset.

Test Plan:
- Reset, write addr 5 with lane j = -(j+1), hold POOLGB_rdy=1 addr 5 -> GBPOOL_val high 3 cycles later; lanes read -1..-16; GBPOOL_cnt=1.
- Back-to-back reads of addrs 0..3 with POOLGB_rdy held high -> 4 transfers spaced 3 cycles apart, correct data each, GBPOOL_cnt=4.
- PEGB_val held high on addr 9 while POOLGB_rdy requests addr 2 -> FETCH stalls until the write stops; returned data equals addr 2 content; no transfer is lost.
- In HOLD for addr 7, write 0x0001 to all lanes of addr 7 -> GBPOOL_val drops, refetch occurs, transferred data is 1 in every lane.
- POOLGB_rdy dropped in HOLD, then Reset pulsed in RESP -> no count increment, GBPOOL_val=0 the following cycle, FSM back in IDLE.
- With GB_POOL_CLR_ON_READ_EN: read addr 3 (value 100 in all lanes), then re-read addr 3 -> second read returns 0 in every lane; GBPE_rdy low for exactly one cycle after the first transfer.

Source files
------------

// File: rtl/gb_pool_responder.sv
// gb_pool_responder: global-buffer side of the POOL read handshake.
// Owns a single-port psum bank written by the PE array and serves POOL reads
// through a FETCH/RESP/HOLD sequence, with refetch on address change or RAW hit.
// Optional build macro: GB_POOL_CLR_ON_READ_EN (zero an entry after it is read).
//
// state | meaning
// IDLE  | no POOL request pending
// FETCH | issue memory read of POOLGB_addr when the port is free
// RESP  | read data available, load response register
// HOLD  | GBPOOL_val high, waiting for POOL to take the word
module gb_pool_responder #(
   parameter int PSUM_WIDTH = 20,
   parameter int NUM_CH     = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         PEGB_val,
   input  logic [ADDR_WIDTH-1:0]        PEGB_addr,
   input  logic [NUM_CH*PSUM_WIDTH-1:0] PEGB_data,
   output logic                         GBPE_rdy,
   input  logic                         POOLGB_rdy,
   input  logic [ADDR_WIDTH-1:0]        POOLGB_addr,
   output logic                         GBPOOL_val,
   output logic [NUM_CH*PSUM_WIDTH-1:0] GBPOOL_data,
   output logic [15:0]                  GBPOOL_cnt
);

   localparam int DW    = NUM_CH * PSUM_WIDTH;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef GB_POOL_CLR_ON_READ_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, FETCH, RESP, HOLD} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
   logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
   logic                    clr_pend_q, clr_pend_d;
   logic [DW-1:0]           data_q, data_d;
   logic                    val_q, val_d;
   logic [15:0]             cnt_q, cnt_d;
   logic [DW-1:0]           rd_data_q;
   logic [DW-1:0]           mem [DEPTH];

   logic wr_fire;
   logic port_busy;
   logic rd_en;
   logic xfer_done;
   logic raw_hit;
   logic addr_chg;

   // A pending clear owns the port for one cycle, so PE writes are held off then.
   assign GBPE_rdy  = !Reset && !clr_pend_q;
   assign wr_fire   = PEGB_val && GBPE_rdy;
   assign port_busy = wr_fire || clr_pend_q;
   assign raw_hit   = wr_fire && (PEGB_addr == req_addr_q);
   assign addr_chg  = (POOLGB_addr != req_addr_q);

   assign GBPOOL_val  = val_q;
   assign GBPOOL_data = data_q;
   assign GBPOOL_cnt  = cnt_q;

   // Next-state, read issue and transfer accounting.
   always_comb begin
      state_d    = state_q;
      req_addr_d = req_addr_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      rd_en      = 1'b0;
      xfer_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (POOLGB_rdy) state_d = FETCH;
         end
         FETCH: begin
            if (!POOLGB_rdy) begin
               state_d = IDLE;
            end else if (!port_busy) begin
               rd_en      = 1'b1;
               req_addr_d = POOLGB_addr;
               state_d    = RESP;
            end
         end
         RESP: begin
            if (!POOLGB_rdy) begin
               state_d = IDLE;
            end else if (addr_chg || raw_hit) begin
               state_d = FETCH;
            end else begin
               data_d  = rd_data_q;
               state_d = HOLD;
            end
         end
         HOLD: begin
            // A RAW hit takes priority over completion so stale data is never counted.
            if (!POOLGB_rdy) begin
               state_d = IDLE;
            end else if (addr_chg || raw_hit) begin
               state_d = FETCH;
            end else begin
               xfer_done = 1'b1;
               cnt_d     = cnt_q + 16'd1;
               state_d   = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
      val_d      = (state_d == HOLD);
      clr_pend_d = CLR_EN && xfer_done;
      clr_addr_d = req_addr_q;
   end

   // Control and response registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         req_addr_q <= '0;
         clr_addr_q <= '0;
         clr_pend_q <= 1'b0;
         data_q     <= '0;
         val_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         req_addr_q <= req_addr_d;
         clr_addr_q <= clr_addr_d;
         clr_pend_q <= clr_pend_d;
         data_q     <= data_d;
         val_q      <= val_d;
         cnt_q      <= cnt_d;
      end
   end

   // Single memory port: PE write, then pending clear, then POOL read. Not reset.
   always_ff @(posedge Clk) begin
      if (wr_fire) begin
         mem[PEGB_addr] <= PEGB_data;
      end else if (clr_pend_q) begin
         mem[clr_addr_q] <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem[POOLGB_addr];
      end
   end

endmodule

// File: tb/tb_gb_pool_responder.sv
// Directed testbench for gb_pool_responder.
module tb_gb_pool_responder;

   localparam int PW = 20;
   localparam int NC = 16;
   localparam int AW = 8;
   localparam int DW = PW * NC;

`ifdef GB_POOL_CLR_ON_READ_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic          Clk;
   logic          Reset;
   logic          PEGB_val;
   logic [AW-1:0] PEGB_addr;
   logic [DW-1:0] PEGB_data;
   logic          GBPE_rdy;
   logic          POOLGB_rdy;
   logic [AW-1:0] POOLGB_addr;
   logic          GBPOOL_val;
   logic [DW-1:0] GBPOOL_data;
   logic [15:0]   GBPOOL_cnt;

   int checks;
   int errors;
   int exp_cnt;
   int cyc;

   gb_pool_responder #(.PSUM_WIDTH(PW), .NUM_CH(NC), .ADDR_WIDTH(AW)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .PEGB_val    (PEGB_val),
      .PEGB_addr   (PEGB_addr),
      .PEGB_data   (PEGB_data),
      .GBPE_rdy    (GBPE_rdy),
      .POOLGB_rdy  (POOLGB_rdy),
      .POOLGB_addr (POOLGB_addr),
      .GBPOOL_val  (GBPOOL_val),
      .GBPOOL_data (GBPOOL_data),
      .GBPOOL_cnt  (GBPOOL_cnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] fill(input int v);
      logic [DW-1:0] r;
      for (int j = 0; j < NC; j++) r[PW*j +: PW] = v[PW-1:0];
      return r;
   endfunction

   function automatic logic [DW-1:0] pat(input int a);
      logic [DW-1:0] r;
      int v;
      for (int j = 0; j < NC; j++) begin
         v = a * 100 + j;
         r[PW*j +: PW] = v[PW-1:0];
      end
      return r;
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic write_word(input int a, input logic [DW-1:0] d);
      PEGB_val  = 1'b1;
      PEGB_addr = a[AW-1:0];
      PEGB_data = d;
      step();
      PEGB_val  = 1'b0;
   endtask

   task automatic wait_val(input int budget, output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      while (n < budget && !ok) begin
         step();
         n++;
         if (GBPOOL_val === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      step();
      step();
      checks++; if (GBPOOL_val !== 1'b0) begin errors++; $display("FAIL reset_val: got %b expected 0", GBPOOL_val); end
      checks++; if (GBPOOL_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", GBPOOL_data); end
      checks++; if (GBPOOL_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", GBPOOL_cnt); end
      checks++; if (GBPE_rdy !== 1'b0) begin errors++; $display("FAIL reset_gbpe_rdy: got %b expected 0", GBPE_rdy); end
      Reset = 1'b0;
      #1;
      checks++; if (GBPE_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_gbpe_rdy: got %b expected 1", GBPE_rdy); end
      exp_cnt = 0;
   endtask

   task automatic test_single_read();
      logic [DW-1:0] exp_d;
      int v;
      for (int j = 0; j < NC; j++) begin
         v = -(j + 1);
         exp_d[PW*j +: PW] = v[PW-1:0];
      end
      write_word(5, exp_d);
      POOLGB_addr = 8'd5;
      POOLGB_rdy  = 1'b1;
      step();
      checks++; if (GBPOOL_val !== 1'b0) begin errors++; $display("FAIL single_val_c1: got %b expected 0", GBPOOL_val); end
      step();
      checks++; if (GBPOOL_val !== 1'b0) begin errors++; $display("FAIL single_val_c2: got %b expected 0", GBPOOL_val); end
      step();
      checks++; if (GBPOOL_val !== 1'b1) begin errors++; $display("FAIL single_val_c3: got %b expected 1", GBPOOL_val); end
      checks++; if (GBPOOL_data !== exp_d) begin errors++; $display("FAIL single_data: got %h expected %h", GBPOOL_data, exp_d); end
      step();
      exp_cnt++;
      checks++; if (GBPOOL_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL single_cnt: got %0d expected %0d", GBPOOL_cnt, exp_cnt); end
      checks++; if (GBPOOL_val !== 1'b0) begin errors++; $display("FAIL single_val_drop: got %b expected 0", GBPOOL_val); end
      POOLGB_rdy = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      bit ok;
      int n;
      int prev;
      for (int a = 0; a < 4; a++) write_word(a, pat(a));
      POOLGB_addr = 8'd0;
      POOLGB_rdy  = 1'b1;
      prev = 0;
      for (int a = 0; a < 4; a++) begin
         wait_val(10, ok, n);
         checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: addr %0d got no valid within 10 cycles expected valid", a); end
         checks++; if (GBPOOL_data !== pat(a)) begin errors++; $display("FAIL b2b_data: addr %0d got %h expected %h", a, GBPOOL_data, pat(a)); end
         if (a > 0) begin
            checks++; if (cyc - prev != 3) begin errors++; $display("FAIL b2b_spacing: got %0d cycles expected 3", cyc - prev); end
         end
         prev = cyc;
         step();
         exp_cnt++;
         if (a == 3) POOLGB_rdy = 1'b0;
         else POOLGB_addr = 8'(a + 1);
      end
      step();
      checks++; if (GBPOOL_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", GBPOOL_cnt, exp_cnt); end
   endtask

   task automatic test_write_stall();
      bit ok;
      int n;
      write_word(2, pat(2));
      POOLGB_addr = 8'd2;
      POOLGB_rdy  = 1'b1;
      PEGB_val    = 1'b1;
      PEGB_addr   = 8'd9;
      PEGB_data   = pat(9);
      for (int i = 0; i < 6; i++) begin
         step();
         checks++; if (GBPOOL_val !== 1'b0) begin errors++; $display("FAIL stall_val: cycle %0d got %b expected 0", i, GBPOOL_val); end
      end
      PEGB_val = 1'b0;
      wait_val(6, ok, n);
      checks++; if (!ok || n != 2) begin errors++; $display("FAIL stall_latency: got ok=%0d after %0d cycles expected ok=1 after 2", ok, n); end
      checks++; if (GBPOOL_data !== pat(2)) begin errors++; $display("FAIL stall_data: got %h expected %h", GBPOOL_data, pat(2)); end
      step();
      exp_cnt++;
      checks++; if (GBPOOL_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL stall_cnt: got %0d expected %0d", GBPOOL_cnt, exp_cnt); end
      POOLGB_addr = 8'd9;
      wait_val(10, ok, n);
      checks++; if (!ok || GBPOOL_data !== pat(9)) begin errors++; $display("FAIL stall_addr9_data: got ok=%0d %h expected %h", ok, GBPOOL_data, pat(9)); end
      step();
      exp_cnt++;
      POOLGB_rdy = 1'b0;
      step();
   endtask

   task automatic test_raw_hazard();
      bit ok;
      int n;
      write_word(7, fill(7));
      POOLGB_addr = 8'd7;
      POOLGB_rdy  = 1'b1;
      wait_val(10, ok, n);
      checks++; if (!ok || GBPOOL_data !== fill(7)) begin errors++; $display("FAIL raw_first_data: got ok=%0d %h expected %h", ok, GBPOOL_data, fill(7)); end
      PEGB_val  = 1'b1;
      PEGB_addr = 8'd7;
      PEGB_data = fill(1);
      step();
      PEGB_val  = 1'b0;
      checks++; if (GBPOOL_val !== 1'b0) begin errors++; $display("FAIL raw_val_drop: got %b expected 0", GBPOOL_val); end
      checks++; if (GBPOOL_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL raw_no_count: got %0d expected %0d", GBPOOL_cnt, exp_cnt); end
      wait_val(6, ok, n);
      checks++; if (!ok || n != 2) begin errors++; $display("FAIL raw_refetch_latency: got ok=%0d after %0d cycles expected ok=1 after 2", ok, n); end
      checks++; if (GBPOOL_data !== fill(1)) begin errors++; $display("FAIL raw_refetch_data: got %h expected %h", GBPOOL_data, fill(1)); end
      step();
      exp_cnt++;
      checks++; if (GBPOOL_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL raw_cnt: got %0d expected %0d", GBPOOL_cnt, exp_cnt); end
      POOLGB_rdy = 1'b0;
      step();
   endtask

   task automatic test_addr_change();
      bit ok;
      int n;
      write_word(0, pat(0));
      write_word(1, pat(1));
      POOLGB_addr = 8'd0;
      POOLGB_rdy  = 1'b1;
      wait_val(10, ok, n);
      POOLGB_addr = 8'd1;
      step();
      checks++; if (GBPOOL_val !== 1'b0 || GBPOOL_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL addrchg_abort: got val=%b cnt=%0d expected val=0 cnt=%0d", GBPOOL_val, GBPOOL_cnt, exp_cnt); end
      wait_val(10, ok, n);
      checks++; if (!ok || GBPOOL_data !== pat(1)) begin errors++; $display("FAIL addrchg_data: got ok=%0d %h expected %h", ok, GBPOOL_data, pat(1)); end
      step();
      exp_cnt++;
      checks++; if (GBPOOL_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL addrchg_cnt: got %0d expected %0d", GBPOOL_cnt, exp_cnt); end
      POOLGB_rdy = 1'b0;
      step();
   endtask

   task automatic test_abort_reset();
      bit ok;
      int n;
      write_word(3, pat(3));
      POOLGB_addr = 8'd3;
      POOLGB_rdy  = 1'b1;
      wait_val(10, ok, n);
      POOLGB_rdy = 1'b0;
      step();
      checks++; if (GBPOOL_val !== 1'b0) begin errors++; $display("FAIL abort_val: got %b expected 0", GBPOOL_val); end
      checks++; if (GBPOOL_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL abort_cnt: got %0d expected %0d", GBPOOL_cnt, exp_cnt); end
      POOLGB_rdy = 1'b1;
      step();
      step();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      checks++; if (GBPOOL_val !== 1'b0) begin errors++; $display("FAIL rst_mid_val: got %b expected 0", GBPOOL_val); end
      checks++; if (GBPOOL_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d expected 0", GBPOOL_cnt); end
      exp_cnt = 0;
      step();
      step();
      checks++; if (GBPOOL_val !== 1'b0) begin errors++; $display("FAIL rst_idle_val_c2: got %b expected 0", GBPOOL_val); end
      step();
      checks++; if (GBPOOL_val !== 1'b1) begin errors++; $display("FAIL rst_idle_val_c3: got %b expected 1", GBPOOL_val); end
      checks++; if (GBPOOL_data !== pat(3)) begin errors++; $display("FAIL rst_mem_kept: got %h expected %h", GBPOOL_data, pat(3)); end
      step();
      exp_cnt++;
      checks++; if (GBPOOL_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL rst_cnt_after: got %0d expected %0d", GBPOOL_cnt, exp_cnt); end
      POOLGB_rdy = 1'b0;
      step();
   endtask

   task automatic test_clear_on_read();
      bit ok;
      int n;
      logic exp_rdy;
      logic [DW-1:0] exp_second;
      exp_rdy    = CLR ? 1'b0 : 1'b1;
      exp_second = CLR ? '0 : fill(100);
      write_word(3, fill(100));
      POOLGB_addr = 8'd3;
      POOLGB_rdy  = 1'b1;
      wait_val(10, ok, n);
      checks++; if (!ok || GBPOOL_data !== fill(100)) begin errors++; $display("FAIL clr_first_data: got ok=%0d %h expected %h", ok, GBPOOL_data, fill(100)); end
      step();
      exp_cnt++;
      POOLGB_rdy = 1'b0;
      checks++; if (GBPE_rdy !== exp_rdy) begin errors++; $display("FAIL clr_gbpe_rdy_low: got %b expected %b", GBPE_rdy, exp_rdy); end
      step();
      checks++; if (GBPE_rdy !== 1'b1) begin errors++; $display("FAIL clr_gbpe_rdy_back: got %b expected 1", GBPE_rdy); end
      POOLGB_rdy = 1'b1;
      wait_val(10, ok, n);
      checks++; if (!ok || GBPOOL_data !== exp_second) begin errors++; $display("FAIL clr_second_data: got ok=%0d %h expected %h", ok, GBPOOL_data, exp_second); end
      step();
      exp_cnt++;
      checks++; if (GBPOOL_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL clr_cnt: got %0d expected %0d", GBPOOL_cnt, exp_cnt); end
      POOLGB_rdy = 1'b0;
      step();
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      exp_cnt     = 0;
      Reset       = 1'b1;
      PEGB_val    = 1'b0;
      PEGB_addr   = '0;
      PEGB_data   = '0;
      POOLGB_rdy  = 1'b0;
      POOLGB_addr = '0;
      test_reset();
      test_single_read();
      test_back_to_back();
      test_write_stall();
      test_raw_hazard();
      test_addr_change();
      test_abort_reset();
      test_clear_on_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
